jk_counter4: RTL and testbench

JK_COUNTER4 -- requirements
Module: jk_counter4

---
 rtl/jk_counter4_pkg.sv | 17 +
 rtl/jk_counter4_jk_cell.sv | 36 +++
 rtl/jk_counter4.sv | 99 +++++++++
 tb/tb_jk_counter4.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/jk_counter4_pkg.sv
// Shared constants for the JK up/down counter and its bench.
//   JK_WIDTH : default counter width
//   JK_ZERO  : all-zeros count value at the default width
//   JK_ONES  : all-ones value at the default width (Qn while Q is cleared)
package jk_counter4_pkg;

    localparam int JK_WIDTH = 4;

    localparam logic [JK_WIDTH-1:0] JK_ZERO = '0;
    localparam logic [JK_WIDTH-1:0] JK_ONES = '1;

    // Classic JK next-state equation, shared so every cell reads the same way.
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        return (j & ~q) | (~k & q);
    endfunction

endpackage

// File: rtl/jk_counter4_jk_cell.sv
// Single-bit JK flip-flop with synchronous active-low clear.
//   CLK : clock, state changes on rising edge
//   CLR : synchronous clear, active low (Q -> 0)
//   J,K : excitation inputs (00 hold, 01 reset, 10 set, 11 toggle)
//   Q   : stored bit
//   Qn  : complement of Q
module jk_cell
    import jk_counter4_pkg::*;
(
    input  logic CLK,
    input  logic CLR,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Qn
);

    logic bit_q;
    logic bit_d;

    always_comb begin
        bit_d = jk_next(bit_q, J, K);
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign Q  = bit_q;
    assign Qn = ~bit_q;

endmodule

// File: rtl/jk_counter4.sv
// Modulo up/down counter built from JK flip-flops.
//   CLK  : clock
//   CLR  : synchronous clear, active low (highest priority)
//   EN   : count enable
//   UP   : direction, 1 = up, 0 = down
//   LOAD : synchronous parallel load of D (clamped to MOD), beats EN
//   D    : load value
//   Terminal value input (port MOD): count range is 0..MOD
//   Q    : registered count
//   Qn   : bitwise complement of Q
//   RCO  : combinational terminal-count flag for the current count direction
module jk_counter4
    import jk_counter4_pkg::*;
#(
    parameter int WIDTH = JK_WIDTH
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] MOD,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             RCO
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] d_sel;
    logic [WIDTH-1:0] count_target;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;

    // Load value is clamped so a load can never place Q outside 0..MOD.
    always_comb begin
        d_sel = (D > MOD) ? MOD : D;
    end

    // Next count value. A count that sits above MOD (MOD lowered under it)
    // is pulled back into range: up -> 0, down -> MOD.
    always_comb begin
        count_target = count;
        if (UP) begin
            if (count < MOD) begin
                count_target = count + WIDTH'(1);
            end else begin
                count_target = '0;
            end
        end else begin
            if (count > MOD || count == '0) begin
                count_target = MOD;
            end else begin
                count_target = count - WIDTH'(1);
            end
        end
    end

    // Bits that must flip to reach the target become J=K=1 (toggle).
    always_comb begin
        toggle = count ^ count_target;
    end

    always_comb begin
        j_vec = '0;
        k_vec = '0;
        if (LOAD) begin
            j_vec = d_sel;
            k_vec = ~d_sel;
        end else if (EN) begin
            j_vec = toggle;
            k_vec = toggle;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_cell u_cell (
                .CLK (CLK),
                .CLR (CLR),
                .J   (j_vec[gi]),
                .K   (k_vec[gi]),
                .Q   (count[gi]),
                .Qn  (Qn[gi])
            );
        end
    endgenerate

    assign Q = count;

    always_comb begin
        RCO = 1'b0;
        if (CLR && !LOAD && EN) begin
            RCO = UP ? (count == MOD) : (count == '0);
        end
    end

endmodule

// File: tb/tb_jk_counter4.sv
module tb_jk_counter4;
    import jk_counter4_pkg::*;

    localparam int W = JK_WIDTH;

    logic         clk;
    logic         clr, en, up, load;
    logic [W-1:0] d, mod_v;
    logic [W-1:0] q, qn;
    logic         rco;

    jk_counter4 #(.WIDTH(W)) dut (
        .CLK  (clk),
        .CLR  (clr),
        .EN   (en),
        .UP   (up),
        .LOAD (load),
        .D    (d),
        .MOD  (mod_v),
        .Q    (q),
        .Qn   (qn),
        .RCO  (rco)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         clr;
        logic         load;
        logic         en;
        logic         up;
        logic [W-1:0] d;
        logic [W-1:0] mod;
        logic [W-1:0] exp_q;
        logic         exp_rco;
        string        name;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] sb_q[$];
    int           checks   = 0;
    int           failures = 0;

    task automatic add(input logic c, input logic l, input logic e, input logic u,
                       input int dv, input int mv, input int eq, input logic er,
                       input string nm);
        vec_t v;
        v.clr = c; v.load = l; v.en = e; v.up = u;
        v.d = W'(dv); v.mod = W'(mv); v.exp_q = W'(eq); v.exp_rco = er; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One transaction: drive away from the edge, check RCO before the edge,
    // push the expected Q, then pop and compare after the edge.
    task automatic step(input logic c, input logic l, input logic e, input logic u,
                        input logic [W-1:0] dv, input logic [W-1:0] mv,
                        input logic [W-1:0] eq, input logic er, input string nm);
        logic [W-1:0] exp_q;
        @(negedge clk);
        clr = c; load = l; en = e; up = u; d = dv; mod_v = mv;
        sb_q.push_back(eq);
        #1;
        check({nm, ".rco"}, W'(rco), W'(er));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s.sb: scoreboard empty, got %h expected an entry", nm, q);
        end else begin
            exp_q = sb_q.pop_front();
            check({nm, ".q"}, q, exp_q);
            check({nm, ".qn"}, qn, JK_ONES ^ exp_q);
            $display("txn %s clr=%b load=%b en=%b up=%b d=%0d mod=%0d -> q=%0d qn=%h rco_pre=%b",
                     nm, c, l, e, u, dv, mv, q, qn, er);
        end
    endtask

    // Behavioural reference for the random phase.
    function automatic logic [W-1:0] model_next(input logic [W-1:0] cq, input logic c,
                                                input logic l, input logic e, input logic u,
                                                input logic [W-1:0] dv, input logic [W-1:0] mv);
        int qi = int'(cq);
        int mi = int'(mv);
        int di = int'(dv);
        if (!c)  return JK_ZERO;
        if (l)   return W'((di > mi) ? mi : di);
        if (!e)  return cq;
        if (u)   return W'((qi < mi) ? qi + 1 : 0);
        if (qi > mi || qi == 0) return W'(mi);
        return W'(qi - 1);
    endfunction

    function automatic logic model_rco(input logic [W-1:0] cq, input logic c, input logic l,
                                       input logic e, input logic u, input logic [W-1:0] mv);
        if (!c || l || !e) return 1'b0;
        return u ? (cq == mv) : (cq == JK_ZERO);
    endfunction

    initial begin
        logic [W-1:0] mq;
        clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; d = '0; mod_v = W'(9);

        // Clear for two edges, then count up through the wrap at MOD=9.
        add(0,0,1,1, 0,9, 0,0, "clr0");
        add(0,0,1,1, 0,9, 0,0, "clr1");
        for (int i = 1; i <= 10; i++) add(1,0,1,1, 0,9, i % 10, (i == 10), "up");
        // Down count from 0: wrap to 9, down to 0, wrap again.
        add(1,0,1,0, 0,9, 9,1, "dn_wrap");
        for (int i = 8; i >= 0; i--) add(1,0,1,0, 0,9, i,0, "dn");
        add(1,0,1,0, 0,9, 9,1, "dn_wrap2");
        // Loads: in range, clamped, and load beating enable.
        add(1,1,0,1, 5,9, 5,0, "load5");
        add(1,1,0,1, 12,9, 9,0, "load_clamp");
        add(1,1,1,1, 3,9, 3,0, "load_vs_en");
        // Mid-count clear at Q=7, resume from 0, then hold for 3 edges.
        add(1,1,0,1, 7,9, 7,0, "load7");
        add(0,0,1,1, 0,9, 0,0, "mid_clr");
        add(1,0,1,1, 0,9, 1,0, "resume");
        for (int i = 0; i < 3; i++) add(1,0,0,1, 0,9, 1,0, "hold");
        // Degenerate MOD=0 range.
        add(1,1,0,1, 0,0, 0,0, "m0_load");
        add(1,0,1,1, 0,0, 0,1, "m0_up0");
        add(1,0,1,1, 0,0, 0,1, "m0_up1");
        add(1,0,1,0, 0,0, 0,1, "m0_dn0");
        add(1,0,1,0, 0,0, 0,1, "m0_dn1");
        add(1,0,0,1, 0,0, 0,0, "m0_noen");
        // Terminal value lowered below Q: up -> 0, down -> MOD, hold when disabled.
        add(1,1,0,1, 8,9, 8,0, "q8a");
        add(1,0,1,1, 0,5, 0,0, "above_up");
        add(1,1,0,1, 8,9, 8,0, "q8b");
        add(1,0,1,0, 0,5, 5,0, "above_dn");
        add(1,1,0,1, 8,9, 8,0, "q8c");
        add(1,0,0,1, 0,5, 8,0, "above_hold");
        // Full-range wrap at MOD=15.
        add(1,1,0,1, 15,15, 15,0, "load15");
        add(1,0,1,1, 0,15, 0,1, "wrap15");

        foreach (vecs[i]) begin
            step(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].d,
                 vecs[i].mod, vecs[i].exp_q, vecs[i].exp_rco, vecs[i].name);
        end

        // Random traffic, including UP flipping every cycle, against the model.
        mq = JK_ZERO;
        for (int i = 0; i < 80; i++) begin
            logic         c, l, e, u;
            logic [W-1:0] dv, mv;
            c  = ($urandom_range(15) != 0);
            l  = ($urandom_range(5) == 0);
            e  = ($urandom_range(3) != 0);
            u  = 1'($urandom_range(1));
            dv = W'($urandom_range(15));
            mv = W'($urandom_range(15));
            step(c, l, e, u, dv, mv, model_next(mq, c, l, e, u, dv, mv),
                 model_rco(mq, c, l, e, u, mv), "rand");
            mq = model_next(mq, c, l, e, u, dv, mv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
